// File: rtl/stage_writeback_if.sv
// stage_writeback_if: instruction, data RAM and byte I/O signals of the writeback stage.
interface stage_writeback_if #(
  parameter int D_WIDTH = 8,
  parameter int A_WIDTH = 12,
  parameter int OPCODE_MSB = 7
);
  logic [OPCODE_MSB:0] operation_in;
  logic [D_WIDTH-1:0] a_in;
  logic [A_WIDTH-1:0] dp_in;
  logic drdy_in;
  logic ack;
  logic [A_WIDTH-1:0] d_addr;
  logic [D_WIDTH-1:0] d_wdata;
  logic d_we;
  logic [D_WIDTH-1:0] out_data;
  logic out_valid;
  logic out_ready;
  logic [D_WIDTH-1:0] in_data;
  logic in_valid;
  logic in_ack;
  logic busy;
  modport master (
    input operation_in, a_in, dp_in, drdy_in, out_ready, in_data, in_valid,
    output ack, d_addr, d_wdata, d_we, out_data, out_valid, in_ack, busy
  );
  modport slave (
    output operation_in, a_in, dp_in, drdy_in, out_ready, in_data, in_valid,
    input ack, d_addr, d_wdata, d_we, out_data, out_valid, in_ack, busy
  );
endinterface

// File: rtl/stage_writeback.sv
// stage_writeback: retires INC/DEC as RAM writes and IN/OUT as handshaked byte transfers,
// stalling upstream through ack while an I/O transfer is outstanding.
module stage_writeback #(
  parameter int D_WIDTH = 8,
  parameter int A_WIDTH = 12,
  parameter int OPCODE_MSB = 7,
  parameter int OP_INC = 0,
  parameter int OP_DEC = 1,
  parameter int OP_IN = 4,
  parameter int OP_OUT = 5
) (
  input logic clk,
  input logic reset,
  stage_writeback_if.master bus
);
  typedef enum logic [1:0] {IDLE, OUT_WAIT, IN_WAIT} state_t;
  state_t state, state_n;
  logic [A_WIDTH-1:0] dp_q, dp_n, addr_n;
  logic [D_WIDTH-1:0] wdata_n, out_data_n;
  logic we_n, out_valid_n, in_ack_n;
  assign bus.ack = bus.drdy_in && state == IDLE && reset;
  assign bus.busy = state != IDLE;
  always_comb begin
    state_n = state;
    dp_n = dp_q;
    addr_n = bus.d_addr;
    wdata_n = bus.d_wdata;
    we_n = 1'b0;
    in_ack_n = 1'b0;
    out_data_n = bus.out_data;
    out_valid_n = bus.out_valid;
    unique case (state)
      IDLE: if (bus.ack) begin
        if (bus.operation_in[OP_IN]) begin
          dp_n = bus.dp_in;
          state_n = IN_WAIT;
        end else if (bus.operation_in[OP_OUT]) begin
          out_data_n = bus.a_in;
          out_valid_n = 1'b1;
          state_n = OUT_WAIT;
        end else if (bus.operation_in[OP_INC] || bus.operation_in[OP_DEC]) begin
          we_n = 1'b1;
          addr_n = bus.dp_in;
          wdata_n = bus.a_in;
        end
      end
      OUT_WAIT: if (bus.out_ready) begin
        out_valid_n = 1'b0;
        state_n = IDLE;
      end
      IN_WAIT: if (bus.in_valid) begin
        in_ack_n = 1'b1;
        we_n = 1'b1;
        addr_n = dp_q;
        wdata_n = bus.in_data;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      dp_q <= '0;
      bus.d_addr <= '0;
      bus.d_wdata <= '0;
      bus.d_we <= 1'b0;
      bus.in_ack <= 1'b0;
      bus.out_data <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      state <= state_n;
      dp_q <= dp_n;
      bus.d_addr <= addr_n;
      bus.d_wdata <= wdata_n;
      bus.d_we <= we_n;
      bus.in_ack <= in_ack_n;
      bus.out_data <= out_data_n;
      bus.out_valid <= out_valid_n;
    end
  end
endmodule

// File: tb/tb_stage_writeback.sv
// tb_stage_writeback: directed scenarios plus a randomized program checked against a
// transaction-level model of RAM contents, output byte stream and input consumption.
module tb_stage_writeback;
  localparam int DW = 8, AW = 12, OM = 7, N = 200;
  localparam logic [7:0] INC = 8'h01, DEC = 8'h02, LEFT = 8'h04, IN = 8'h10, OUT = 8'h20;
  typedef struct {logic [7:0] op; logic [11:0] dp; logic [7:0] a;} ins_t;
  logic clk = 1'b0, reset = 1'b1;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  stage_writeback_if #(.D_WIDTH(DW), .A_WIDTH(AW), .OPCODE_MSB(OM)) bus ();
  stage_writeback #(.D_WIDTH(DW), .A_WIDTH(AW), .OPCODE_MSB(OM)) dut (.clk(clk), .reset(reset), .bus(bus));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [7:0] op, input logic [11:0] dp, input logic [7:0] a, input logic v);
    bus.operation_in = op;
    bus.dp_in = dp;
    bus.a_in = a;
    bus.drdy_in = v;
  endtask
  ins_t prog[N];
  logic [7:0] src[256];
  logic [7:0] mram[16], tram[16], opts[6], s_op[3], s_a[3];
  logic [7:0] exp_q[$], got_q[$];
  initial begin
    int idx, in_idx, k, n_in;
    logic acc, held;
    opts = '{INC, DEC, IN, OUT, 8'h00, LEFT};
    s_op = '{INC, DEC, INC};
    s_a = '{8'h01, 8'hFF, 8'h80};
    drive(8'h00, 12'h000, 8'h00, 1'b1);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    #1 reset = 1'b0;
    #1;
    chk("rst_ack", bus.ack, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_we", bus.d_we, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ack", bus.in_ack, 0);
    // reset then a single INC
    @(negedge clk) reset = 1'b1;
    drive(INC, 12'h005, 8'h2A, 1'b1);
    #1 chk("inc_ack", bus.ack, 1);
    tick;
    chk("inc_we", bus.d_we, 1);
    chk("inc_addr", bus.d_addr, 12'h005);
    chk("inc_data", bus.d_wdata, 8'h2A);
    drive(8'h00, 12'h000, 8'h00, 1'b0);
    tick;
    chk("inc_we_off", bus.d_we, 0);
    // streaming INC/DEC at full rate
    for (int i = 0; i < 3; i++) begin
      drive(s_op[i], 12'(i + 1), s_a[i], 1'b1);
      #1 chk("str_ack", bus.ack, 1);
      tick;
      chk("str_we", bus.d_we, 1);
      chk("str_addr", bus.d_addr, i + 1);
      chk("str_data", bus.d_wdata, s_a[i]);
    end
    drive(8'h00, 12'h000, 8'h00, 1'b0);
    tick;
    chk("str_we_off", bus.d_we, 0);
    // OUT with backpressure, then a queued INC
    drive(OUT, 12'h000, 8'h41, 1'b1);
    #1 chk("out_ack", bus.ack, 1);
    tick;
    drive(INC, 12'h007, 8'h09, 1'b1);
    for (int i = 0; i < 5; i++) begin
      bus.out_ready = (i == 4);
      #1;
      chk("out_valid", bus.out_valid, 1);
      chk("out_data", bus.out_data, 8'h41);
      chk("out_stall_ack", bus.ack, 0);
      chk("out_busy", bus.busy, 1);
      chk("out_no_we", bus.d_we, 0);
      tick;
    end
    bus.out_ready = 1'b0;
    #1;
    chk("out_fall", bus.out_valid, 0);
    chk("out_next_ack", bus.ack, 1);
    tick;
    chk("out_next_we", bus.d_we, 1);
    chk("out_next_addr", bus.d_addr, 12'h007);
    drive(8'h00, 12'h000, 8'h00, 1'b0);
    // IN with a stalled source
    drive(IN, 12'h010, 8'h55, 1'b1);
    #1 chk("in_accept", bus.ack, 1);
    tick;
    drive(8'h00, 12'h000, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("in_busy", bus.busy, 1);
      chk("in_ack_wait", bus.in_ack, 0);
      chk("in_we_wait", bus.d_we, 0);
      tick;
    end
    bus.in_valid = 1'b1;
    bus.in_data = 8'h7E;
    tick;
    bus.in_valid = 1'b0;
    chk("in_ack", bus.in_ack, 1);
    chk("in_we", bus.d_we, 1);
    chk("in_addr", bus.d_addr, 12'h010);
    chk("in_data", bus.d_wdata, 8'h7E);
    chk("in_idle", bus.busy, 0);
    tick;
    chk("in_ack_off", bus.in_ack, 0);
    chk("in_we_off", bus.d_we, 0);
    // asynchronous reset while an output byte is pending
    drive(OUT, 12'h000, 8'h33, 1'b1);
    tick;
    drive(8'h00, 12'h000, 8'h00, 1'b0);
    chk("mid_out_valid", bus.out_valid, 1);
    @(negedge clk) reset = 1'b0;
    #1;
    chk("mid_async_valid", bus.out_valid, 0);
    chk("mid_async_busy", bus.busy, 0);
    chk("mid_async_data", bus.out_data, 0);
    bus.in_valid = 1'b1;
    @(negedge clk) reset = 1'b1;
    tick;
    chk("mid_rel_valid", bus.out_valid, 0);
    chk("mid_rel_in_ack", bus.in_ack, 0);
    chk("mid_rel_we", bus.d_we, 0);
    chk("mid_rel_busy", bus.busy, 0);
    bus.in_valid = 1'b0;
    // bubble, then illegal IN|OUT behaves as IN
    drive(8'h00, 12'h003, 8'h99, 1'b1);
    #1 chk("bub_ack", bus.ack, 1);
    tick;
    chk("bub_we", bus.d_we, 0);
    chk("bub_out", bus.out_valid, 0);
    chk("bub_busy", bus.busy, 0);
    drive(IN | OUT, 12'h020, 8'h99, 1'b1);
    #1 chk("ill_ack", bus.ack, 1);
    tick;
    drive(8'h00, 12'h000, 8'h00, 1'b0);
    chk("ill_busy", bus.busy, 1);
    chk("ill_out", bus.out_valid, 0);
    bus.in_valid = 1'b1;
    bus.in_data = 8'h11;
    tick;
    bus.in_valid = 1'b0;
    chk("ill_in_ack", bus.in_ack, 1);
    chk("ill_addr", bus.d_addr, 12'h020);
    chk("ill_data", bus.d_wdata, 8'h11);
    tick;
    // randomized program against a transaction-level model
    for (int i = 0; i < N; i++) begin
      prog[i].op = opts[$urandom_range(0, 5)];
      prog[i].dp = 12'($urandom_range(0, 15));
      prog[i].a = 8'($urandom);
    end
    for (int i = 0; i < 256; i++) src[i] = 8'($urandom);
    for (int i = 0; i < 16; i++) begin
      mram[i] = 8'h00;
      tram[i] = 8'h00;
    end
    k = 0;
    for (int i = 0; i < N; i++) begin
      if (prog[i].op == IN) mram[prog[i].dp[3:0]] = src[k++];
      else if (prog[i].op == OUT) exp_q.push_back(prog[i].a);
      else if (prog[i].op == INC || prog[i].op == DEC) mram[prog[i].dp[3:0]] = prog[i].a;
    end
    n_in = k;
    idx = 0;
    in_idx = 0;
    acc = 1'b0;
    held = 1'b0;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      tick;
      if (bus.d_we) tram[bus.d_addr[3:0]] = bus.d_wdata;
      if (bus.in_ack) in_idx++;
      if (acc) begin
        idx++;
        held = 1'b0;
      end
      if (idx == N && !bus.busy) break;
      if (idx < N) drive(prog[idx].op, prog[idx].dp, prog[idx].a, held || $urandom_range(0, 3) != 0);
      else drive(8'h00, 12'h000, 8'h00, 1'b0);
      held = bus.drdy_in;
      bus.out_ready = 1'($urandom_range(0, 1));
      bus.in_valid = $urandom_range(0, 2) == 0;
      bus.in_data = src[in_idx[7:0]];
      #1;
      acc = bus.ack;
      if (bus.out_valid && bus.out_ready) got_q.push_back(bus.out_data);
    end
    drive(8'h00, 12'h000, 8'h00, 1'b0);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b0;
    chk("rnd_retired", idx, N);
    chk("rnd_in_count", in_idx, n_in);
    chk("rnd_out_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) chk("rnd_out_byte", got_q[i], exp_q[i]);
    for (int i = 0; i < 16; i++) chk("rnd_ram", tram[i], mram[i]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
